// File: rtl/uart_buffer.sv
// Byte buffer between the CPU port decoder and the uart core: TX FIFO feeding the
// transmitter, RX FIFO absorbing received bytes. Optional build macro: UART_BUFFER_RXHOLD_EN.
module uart_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_bus,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_req,
  input  logic                  rd_req,
  output logic [7:0]            rd_data,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  tx_full,
  output logic                  rx_empty,
  output logic                  tx_ovf,
  output logic                  rx_ovf,
  input  logic                  clr_ovf,
  output logic [7:0]            txdata,
  output logic                  txbegin,
  input  logic                  txbusy,
  input  logic [7:0]            rxdata,
  input  logic                  rxrecv,
  output logic                  data_read,
  output logic [1:0]            tx_state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int W = DEPTH_LOG2 + 1;
  localparam logic [W-1:0] FULL_CNT = W'(DEPTH);

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_ISSUE = 2'd1,
    T_BUSY  = 2'd2
  } tx_state_t;

  tx_state_t tx_state;

  logic [7:0]            tx_mem [DEPTH];
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic                  tx_empty, rx_full;
  logic                  tx_push, tx_pop, rx_push, rx_pop, rx_take;
  logic                  rst_pend;
`ifdef UART_BUFFER_RXHOLD_EN
  logic                  rx_pend;
`endif

  // Handshakes: txbegin is a one-cycle command, only issued while txbusy=0;
  // rxrecv is held by the receiver until data_read pulses, so rxrecv is ignored
  // while data_read is high and in the first cycle after reset release.
  assign tx_full      = (tx_count == FULL_CNT);
  assign tx_empty     = (tx_count == '0);
  assign rx_full      = (rx_count == FULL_CNT);
  assign rx_empty     = (rx_count == '0);
  assign rd_data      = rx_empty ? 8'h00 : rx_mem[rx_rp];
  assign tx_state_dbg = tx_state;

  assign tx_push = wr_req && !tx_full;
  assign tx_pop  = (tx_state == T_IDLE) && !tx_empty && !txbusy;
  assign rx_pop  = rd_req && !rx_empty;
  assign rx_take = rxrecv && !data_read && !rst_pend;
`ifdef UART_BUFFER_RXHOLD_EN
  assign rx_push = (rx_take || rx_pend) && !rx_full;
`else
  assign rx_push = rx_take && !rx_full;
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_bus) begin
    if (tx_push) tx_mem[tx_wp] <= wr_data;
    if (rx_push) rx_mem[rx_wp] <= rxdata;
  end

  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      tx_ovf   <= 1'b0;
      tx_state <= T_IDLE;
      txbegin  <= 1'b0;
      txdata   <= 8'h00;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_count <= tx_count + W'(tx_push) - W'(tx_pop);
      if (wr_req && tx_full) tx_ovf <= 1'b1;
      else if (clr_ovf)      tx_ovf <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          if (tx_pop) begin
            txdata   <= tx_mem[tx_rp];
            txbegin  <= 1'b1;
            tx_state <= T_ISSUE;
          end
        end
        T_ISSUE: begin
          txbegin  <= 1'b0;
          tx_state <= T_BUSY;
        end
        T_BUSY: begin
          if (!txbusy) tx_state <= T_IDLE;
        end
        default: begin
          txbegin  <= 1'b0;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_count  <= '0;
      rx_ovf    <= 1'b0;
      data_read <= 1'b0;
      rst_pend  <= 1'b1;
`ifdef UART_BUFFER_RXHOLD_EN
      rx_pend   <= 1'b0;
`endif
    end else begin
      rst_pend <= 1'b0;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_count <= rx_count + W'(rx_push) - W'(rx_pop);
`ifdef UART_BUFFER_RXHOLD_EN
      // A byte arriving into a full FIFO waits here, unacknowledged, for room.
      data_read <= rst_pend || rx_push;
      if (rx_push)               rx_pend <= 1'b0;
      else if (rx_take && rx_full) rx_pend <= 1'b1;
      if (clr_ovf) rx_ovf <= 1'b0;
`else
      data_read <= rst_pend || rx_take;
      if (rx_take && rx_full) rx_ovf <= 1'b1;
      else if (clr_ovf)       rx_ovf <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/uart_buffer.md
# uart_buffer

Byte-buffering stage between the CPU port decoder and the `uart` core, on the `clk_bus` domain. It holds a TX FIFO that feeds the transmitter one byte at a time through its `txbegin`/`txbusy` handshake. It holds an RX FIFO that absorbs each `rxrecv` byte from the receiver and acknowledges it with `data_read`. The CPU side gets first-word-fall-through read data, fill counts and sticky overflow flags.

## Interface
- `DEPTH_LOG2`, 4, log2 of each FIFO depth (16 entries); count width W = DEPTH_LOG2+1
- `clk_bus` in 1: the single clock
- `reset` in 1: asynchronous, active-high
- `wr_data` in 8: byte to push into the TX FIFO
- `wr_req` in 1: one-cycle push strobe
- `rd_req` in 1: one-cycle pop strobe for the RX FIFO
- `rd_data` out 8: RX FIFO head; 8'h00 when empty
- `tx_count` out W: TX FIFO occupancy
- `rx_count` out W: RX FIFO occupancy
- `tx_full`, `rx_empty` out 1: status flags
- `tx_ovf`, `rx_ovf` out 1: sticky overflow flags
- `clr_ovf` in 1: clears both overflow flags
- `txdata` out 8, `txbegin` out 1, `txbusy` in 1: transmitter side
- `rxdata` in 8, `rxrecv` in 1, `data_read` out 1: receiver side

## Operation
- **FIFOs**
  - Circular buffers; read/write pointers wrap modulo 2^DEPTH_LOG2.
  - Full/empty are judged on the count at the start of the cycle.
  - A push to a full FIFO is rejected even when a pop happens in the same cycle.
  - A pop from an empty FIFO is ignored. A push with a pop on an empty FIFO accepts the push only.
- **CPU TX push:** `wr_req` with `tx_full`=1 drops the byte and sets `tx_ovf`.
- **TX FSM, states T_IDLE, T_ISSUE, T_BUSY**
  - T_IDLE → T_ISSUE when the TX FIFO is non-empty and `txbusy`=0. On this transition the block registers `txdata`=head and `txbegin`=1, and pops the FIFO.
  - T_ISSUE → T_BUSY unconditionally, with `txbegin`=0. `txbegin` is high for exactly one cycle, because the transmitter only advances while `txbegin`=0.
  - T_BUSY → T_IDLE when `txbusy`=0.
- **RX path**
  - On `rxrecv`=1 with room, push `rxdata` and register `data_read`=1 for one cycle.
  - On `rxrecv`=1 with the RX FIFO full, the behaviour is set by the configuration (see below).
- **Overflow flags:** `clr_ovf` clears both. A set event in the same cycle as `clr_ovf` wins.
- **Reset**
  - Async `reset` zeroes pointers, counts, flags, `txbegin`, `txdata` and `data_read`, and forces T_IDLE. FIFO storage is not reset.
  - In the first cycle after `reset` deasserts, `data_read` pulses once. This releases a receiver left waiting with an un-acknowledged byte; that byte is discarded.
  - If the transmitter is mid-byte at reset release, T_IDLE holds off until `txbusy`=0.

## Timing
- **Edge numbering:** edges E0, E1, E2, E3, with E0 being the edge that samples `wr_req`.
- **TX, byte into an idle transmitter:**
  - E0 samples `wr_req`; `tx_count` increments after E0.
  - `txbegin` is registered at E1, so it is high between E1 and E2.
  - The transmitter latches the byte at E2 and `txbusy` rises. `txbegin` falls at E2.
  - Latency from `wr_req` to `txbegin` is 1 cycle.
- **TX, back-to-back bytes:** the next `txbegin` is asserted at the edge after the one at which `txbusy` is sampled 0.
- **RX:**
  - `rxrecv` sampled high at edge E0 → push and `data_read`=1 after E0.
  - `data_read` is low again after E1.
  - `rx_empty` falls and `rd_data` is valid after E0.
- **RX pop:** `rd_req` at edge E0 → the next head appears on `rd_data` after E0.
- **Registered outputs:** all outputs are registered except `rd_data`, `tx_full` and `rx_empty`, which are decoded from registers.

## Configuration
- Macro: `UART_BUFFER_RXHOLD_EN`.
- **Defined:** `rxrecv` with the RX FIFO full sets an internal pending flag and withholds `data_read`.
  - The receiver stays in its wait state, keeps `rts` high and holds `rxdata` stable.
  - In the first cycle with `rx_count` < depth, the byte is pushed and `data_read` pulses.
  - `rx_ovf` never sets.
- **Undefined:** `rxrecv` with the RX FIFO full drops the byte, sets `rx_ovf` and pulses `data_read` on the normal schedule.

## Test plan
- **Single TX byte:** reset, then `wr_req` with 8'hA5 and `txbusy`=0 → `txdata`=8'hA5 and a 1-cycle `txbegin` one cycle later; `tx_count` goes 0→1→0.
- **TX stream:** push 16 bytes 8'h00..8'h0F (FIFO empty, pushes land before the first issue) → `tx_full`=1 and `tx_ovf` stays 0. A 17th push with `tx_full`=1 sets `tx_ovf`. The transmitter model then emits 8'h00..8'h0F in order, one `txbegin` per `txbusy` fall.
- **RX path:** pulse `rxrecv` with 8'h3C → `data_read` pulses one cycle later; `rd_data`=8'h3C and `rx_count`=1; after `rd_req`, `rx_empty`=1 and `rd_data`=8'h00.
- **RX overflow, macro undefined:** 17 `rxrecv` bytes with no reads → `rx_ovf`=1, 17 `data_read` pulses, and the FIFO holds the first 16 bytes. `clr_ovf` clears `rx_ovf`.
- **RX overflow, `UART_BUFFER_RXHOLD_EN` defined:** 17th byte 8'h77 arrives → no `data_read`. A single `rd_req` → `data_read` pulses and 8'h77 is pushed; `rx_count` returns to 16.
- **Reset mid-operation:** assert `reset` during T_BUSY with `txbusy`=1 and 3 bytes queued → counts go to 0 and `txbegin`=0. After release, `data_read` pulses once. No `txbegin` occurs until `txbusy`=0, and then only for newly pushed bytes.
